pmem_acc_ctrl: RTL



---
 rtl/pmem_acc_pkg.sv | 22 ++
 rtl/psum_vec_add.sv | 34 +++
 rtl/pmem_acc_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pmem_acc_pkg.sv
// Shared types and defaults for the PMEM accumulation controller.
// Lane i of a psum vector occupies bits [lane_lsb(i, bw) +: bw].
package pmem_acc_pkg;

    localparam int PSUM_BW_DEFAULT  = 16;
    localparam int COL_DEFAULT      = 8;
    localparam int NUM_ROWS_DEFAULT = 16;
    localparam int NUM_KIJ_DEFAULT  = 9;
    localparam int ADDR_W_DEFAULT   = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } acc_state_t;

    function automatic int lane_lsb(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/psum_vec_add.sv
// Combinational per-lane signed wrapping add of a psum vector onto a stored row.
// first bypasses the stored row; last_relu clamps negative lanes to zero.
module psum_vec_add
    import pmem_acc_pkg::*;
#(
    parameter int COL     = COL_DEFAULT,
    parameter int PSUM_BW = PSUM_BW_DEFAULT
) (
    input  logic [COL*PSUM_BW-1:0] vec,
    input  logic [COL*PSUM_BW-1:0] acc,
    input  logic                   first,
    input  logic                   last_relu,
    output logic [COL*PSUM_BW-1:0] sum
);

    logic [PSUM_BW-1:0] lane;

    always_comb begin
        sum  = '0;
        lane = '0;
        for (int i = 0; i < COL; i++) begin
            lane = vec[lane_lsb(i, PSUM_BW) +: PSUM_BW];
            if (!first) begin
                lane = lane + acc[lane_lsb(i, PSUM_BW) +: PSUM_BW];
            end
            // sign bit set means the lane is negative
            if (last_relu && lane[PSUM_BW-1]) begin
                lane = '0;
            end
            sum[lane_lsb(i, PSUM_BW) +: PSUM_BW] = lane;
        end
    end

endmodule

// File: rtl/pmem_acc_ctrl.sv
// Drains one OFIFO vector per row into PMEM with read-modify-write accumulation.
// Two cycles per row (RD then WR); an empty OFIFO holds the FSM in RD.
module pmem_acc_ctrl
    import pmem_acc_pkg::*;
#(
    parameter int COL      = COL_DEFAULT,
    parameter int PSUM_BW  = PSUM_BW_DEFAULT,
    parameter int NUM_ROWS = NUM_ROWS_DEFAULT,
    parameter int NUM_KIJ  = NUM_KIJ_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int ACC_BASE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             kij_idx,
    input  logic                   relu_en,
    input  logic                   ofifo_valid,
    input  logic [COL*PSUM_BW-1:0] ofifo_out,
    output logic                   ofifo_rd,
    input  logic [COL*PSUM_BW-1:0] mem_q,
    output logic [COL*PSUM_BW-1:0] mem_d,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic                   busy,
    output logic                   done
);

    localparam int VEC_W = COL * PSUM_BW;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    acc_state_t         state;
    acc_state_t         state_nxt;
    logic [ROW_W-1:0]   row;
    logic               first_r;
    logic               relu_r;
    logic [VEC_W-1:0]   vec_r;
    logic [VEC_W-1:0]   sum;
    logic [ADDR_W-1:0]  row_addr;
    logic               last_row;

    assign row_addr = ADDR_W'(ACC_BASE) + ADDR_W'(row);
    assign last_row = (row == ROW_W'(NUM_ROWS - 1));

    psum_vec_add #(
        .COL     (COL),
        .PSUM_BW (PSUM_BW)
    ) u_add (
        .vec       (vec_r),
        .acc       (mem_q),
        .first     (first_r),
        .last_relu (relu_r),
        .sum       (sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            row     <= '0;
            first_r <= 1'b0;
            relu_r  <= 1'b0;
            vec_r   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        first_r <= (kij_idx == 4'd0);
                        relu_r  <= relu_en && (kij_idx == 4'(NUM_KIJ - 1));
                        row     <= '0;
                    end
                end
                ST_RD: begin
                    if (ofifo_valid) begin
                        vec_r <= ofifo_out;
                    end
                end
                ST_WR: begin
                    // hold on the last row; the counter only wraps through FIN
                    if (!last_row) begin
                        row <= row + 1'b1;
                    end
                end
                ST_FIN: begin
                    row <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        ofifo_rd  = 1'b0;
        mem_cen   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = '0;
        mem_d     = '0;
        done      = 1'b0;
        busy      = (state == ST_RD) || (state == ST_WR);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                mem_addr = row_addr;
                // read issue is gated by the FIFO head so a stalled RD leaves the SRAM idle
                if (ofifo_valid) begin
                    ofifo_rd  = 1'b1;
                    mem_cen   = first_r;
                    state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                mem_cen   = 1'b0;
                mem_wen   = 1'b0;
                mem_addr  = row_addr;
                mem_d     = sum;
                state_nxt = last_row ? ST_FIN : ST_RD;
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
